lfsr_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 37 +++
 rtl/lfsr_checker_predict.sv | 28 ++
 rtl/lfsr_checker.sv | 203 ++++++++++++++++++++
 tb/tb_lfsr_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS checker: per-width tap masks, the single
// LFSR step used by both generator and checker, and the lock FSM states.
package lfsr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    // Feedback tap mask for a given state width (bit n-1 stands for tap n).
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] taps;
        case (width)
            32'd8:   taps = 64'h0000_0000_0000_00B8;  // 8,6,5,4
            32'd16:  taps = 64'h0000_0000_0000_B400;  // 16,14,13,11
            32'd32:  taps = 64'h0000_0000_8020_0003;  // 32,22,2,1
            default: taps = 64'h0000_0000_0000_B400;
        endcase
        return taps;
    endfunction

    // One Fibonacci step: shift left, new LSB is the XOR of the tapped bits.
    function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                              input int unsigned width);
        logic [63:0] mask;
        logic        fb;
        if (width >= 32'd64) begin
            mask = {64{1'b1}};
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        fb = ^(state & lfsr_taps(width));
        return {state[62:0], fb} & mask;
    endfunction

endpackage

// File: rtl/lfsr_checker_predict.sv
// lfsr_predict: expands the predictor seed into the POLY words expected on
// the next beat and the seed for the beat after. Purely combinational so it
// can sit in the generator chain as well.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int POLY  = 8
) (
    input  logic [WIDTH-1:0]      pred,
    output logic [POLY*WIDTH-1:0] exp_beat,
    output logic [WIDTH-1:0]      pred_next
);

    logic [WIDTH-1:0] word_s;

    // Unroll the LFSR chain: word 0 is the seed, each later word one step on.
    always_comb begin
        word_s   = pred;
        exp_beat = {(POLY*WIDTH){1'b0}};
        for (int i = 0; i < POLY; i++) begin
            exp_beat[i*WIDTH +: WIDTH] = word_s;
            word_s = WIDTH'(lfsr_next(64'(word_s), WIDTH));
        end
        pred_next = word_s;
    end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising PRBS checker for a parallel LFSR stream.
// Optional first-error capture outputs are built when LFSR_CHK_CAPTURE_EN
// is defined.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter  int WIDTH        = 16,
    parameter  int POLY         = 8,
    parameter  int LOCK_BEATS   = 4,
    parameter  int UNLOCK_BEATS = 3,
    parameter  int CNT_W        = 32,
    localparam int IDX_W        = (POLY > 1) ? $clog2(POLY) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [POLY*WIDTH-1:0] in_data,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      beat_cnt
`ifdef LFSR_CHK_CAPTURE_EN
    ,
    output logic                  cap_valid,
    output logic [IDX_W-1:0]      cap_idx,
    output logic [WIDTH-1:0]      cap_exp,
    output logic [WIDTH-1:0]      cap_rx
`endif
);

    localparam int BEAT_W = POLY * WIDTH;
    localparam int PC_W   = $clog2(BEAT_W + 1);
    localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int GOOD_W = $clog2(LOCK_BEATS + 1);
    localparam int BAD_W  = $clog2(UNLOCK_BEATS + 1);
    localparam logic [SUM_W-1:0] CNT_MAX_EXT = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    state_t            state_r;
    logic [WIDTH-1:0]  pred_r;
    logic [GOOD_W-1:0] good_cnt_r;
    logic [BAD_W-1:0]  bad_cnt_r;

    logic [BEAT_W-1:0] exp_beat_s;
    logic [BEAT_W-1:0] diff_s;
    logic [WIDTH-1:0]  pred_next_s;
    logic [WIDTH-1:0]  reseed_s;
    logic              reseed_ok_s;
    logic [PC_W-1:0]   pop_s;
    logic [SUM_W-1:0]  err_sum_s;
    logic [CNT_W-1:0]  err_acc_s;
    logic [CNT_W-1:0]  beat_acc_s;

    lfsr_predict #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_predict (
        .pred      (pred_r),
        .exp_beat  (exp_beat_s),
        .pred_next (pred_next_s)
    );

    // Bit mismatches and the reseed candidate taken from the last received word.
    always_comb begin
        diff_s      = in_data ^ exp_beat_s;
        reseed_s    = WIDTH'(lfsr_next(64'(in_data[(POLY-1)*WIDTH +: WIDTH]), WIDTH));
        reseed_ok_s = (in_data[(POLY-1)*WIDTH +: WIDTH] != {WIDTH{1'b0}});
    end

    // Count mismatching bits across the whole beat.
    always_comb begin
        pop_s = {PC_W{1'b0}};
        for (int i = 0; i < BEAT_W; i++) begin
            pop_s = pop_s + PC_W'(diff_s[i]);
        end
    end

    // Saturating next values for the error and beat counters.
    always_comb begin
        err_sum_s = SUM_W'(err_cnt) + SUM_W'(pop_s);
        if (err_sum_s > CNT_MAX_EXT) begin
            err_acc_s = {CNT_W{1'b1}};
        end else begin
            err_acc_s = err_sum_s[CNT_W-1:0];
        end
        if (beat_cnt == {CNT_W{1'b1}}) begin
            beat_acc_s = beat_cnt;
        end else begin
            beat_acc_s = beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Lock FSM with its predictor, run-length counters and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= HUNT;
            pred_r     <= {WIDTH{1'b0}};
            good_cnt_r <= {GOOD_W{1'b0}};
            bad_cnt_r  <= {BAD_W{1'b0}};
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state_r)
                    HUNT: begin
                        // An all-zero word is the LFSR lock-up state: never seed from it.
                        if (reseed_ok_s) begin
                            pred_r     <= reseed_s;
                            good_cnt_r <= {GOOD_W{1'b0}};
                            state_r    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (diff_s == {BEAT_W{1'b0}}) begin
                            pred_r <= pred_next_s;
                            if (good_cnt_r == GOOD_W'(LOCK_BEATS - 1)) begin
                                good_cnt_r <= {GOOD_W{1'b0}};
                                bad_cnt_r  <= {BAD_W{1'b0}};
                                state_r    <= LOCK;
                                locked     <= 1'b1;
                            end else begin
                                good_cnt_r <= good_cnt_r + {{(GOOD_W-1){1'b0}}, 1'b1};
                            end
                        end else if (reseed_ok_s) begin
                            pred_r     <= reseed_s;
                            good_cnt_r <= {GOOD_W{1'b0}};
                        end else begin
                            good_cnt_r <= {GOOD_W{1'b0}};
                            state_r    <= HUNT;
                        end
                    end
                    LOCK: begin
                        // Once locked the predictor free-runs; errors never reseed it.
                        pred_r <= pred_next_s;
                        if (pop_s != {PC_W{1'b0}}) begin
                            err_pulse <= 1'b1;
                            if (bad_cnt_r == BAD_W'(UNLOCK_BEATS - 1)) begin
                                bad_cnt_r <= {BAD_W{1'b0}};
                                state_r   <= HUNT;
                                locked    <= 1'b0;
                            end else begin
                                bad_cnt_r <= bad_cnt_r + {{(BAD_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            bad_cnt_r <= {BAD_W{1'b0}};
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Error and beat statistics while locked; clear takes priority over accumulation.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_cnt  <= {CNT_W{1'b0}};
            beat_cnt <= {CNT_W{1'b0}};
        end else if (in_valid && (state_r == LOCK)) begin
            err_cnt  <= err_acc_s;
            beat_cnt <= beat_acc_s;
        end else begin
            err_cnt  <= err_cnt;
            beat_cnt <= beat_cnt;
        end
    end

`ifdef LFSR_CHK_CAPTURE_EN
    logic [IDX_W-1:0] first_idx_s;

    // Lowest-indexed mismatching word of the current beat.
    always_comb begin
        first_idx_s = {IDX_W{1'b0}};
        for (int i = POLY - 1; i >= 0; i--) begin
            if (diff_s[i*WIDTH +: WIDTH] != {WIDTH{1'b0}}) begin
                first_idx_s = IDX_W'(i);
            end
        end
    end

    // Sticky snapshot of the first errored beat seen while locked.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cap_valid <= 1'b0;
            cap_idx   <= {IDX_W{1'b0}};
            cap_exp   <= {WIDTH{1'b0}};
            cap_rx    <= {WIDTH{1'b0}};
        end else if (in_valid && (state_r == LOCK) && (pop_s != {PC_W{1'b0}}) && !cap_valid) begin
            cap_valid <= 1'b1;
            cap_idx   <= first_idx_s;
            cap_exp   <= exp_beat_s[first_idx_s*WIDTH +: WIDTH];
            cap_rx    <= in_data[first_idx_s*WIDTH +: WIDTH];
        end else begin
            cap_valid <= cap_valid;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed scoreboard bench for lfsr_checker: a 32-bit counter instance and a
// 4-bit counter instance see the same stream.
module tb_lfsr_checker;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic [127:0] in_data;

    logic         locked_a, err_pulse_a;
    logic [31:0]  err_cnt_a, beat_cnt_a;
    logic         locked_b, err_pulse_b;
    logic [3:0]   err_cnt_b, beat_cnt_b;

    always #5 clk = ~clk;

    lfsr_checker dut_a (
        .clk (clk), .reset (reset), .clear (clear),
        .in_valid (in_valid), .in_data (in_data),
        .locked (locked_a), .err_pulse (err_pulse_a),
        .err_cnt (err_cnt_a), .beat_cnt (beat_cnt_a)
    );

    lfsr_checker #(.CNT_W(4)) dut_b (
        .clk (clk), .reset (reset), .clear (clear),
        .in_valid (in_valid), .in_data (in_data),
        .locked (locked_b), .err_pulse (err_pulse_b),
        .err_cnt (err_cnt_b), .beat_cnt (beat_cnt_b)
    );

    typedef struct packed {
        logic        lk;
        logic        pl;
        logic [31:0] err;
        logic [31:0] beat;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [15:0]  gen;
    logic [127:0] d;

    // Reference step: shift left, new LSB = s[15]^s[13]^s[12]^s[10].
    function automatic logic [15:0] nxt(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [31:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 32'd15 : v;
    endfunction

    task automatic next_beat(output logic [127:0] o);
        for (int i = 0; i < 8; i++) begin
            o[i*16 +: 16] = gen;
            gen = nxt(gen);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after that edge.
    task automatic cyc(input logic r, input logic c, input logic v, input logic [127:0] dd,
                       input logic lk, input logic pl, input int unsigned ea, input int unsigned ba);
        exp_t e;
        @(posedge clk);
        #2;
        reset    = r;
        clear    = c;
        in_valid = v;
        in_data  = dd;
        e.lk   = lk;
        e.pl   = pl;
        e.err  = ea;
        e.beat = ba;
        sb_q.push_back(e);
    endtask

    // Monitor: after each edge, pop the expectation for the cycle just sampled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("locked",     {31'd0, locked_a},    {31'd0, e.lk});
                check("err_pulse",  {31'd0, err_pulse_a}, {31'd0, e.pl});
                check("err_cnt",    err_cnt_a,            e.err);
                check("beat_cnt",   beat_cnt_a,           e.beat);
                check("err_cnt_w4", {28'd0, err_cnt_b},   sat4(e.err));
                check("beat_cnt_w4",{28'd0, beat_cnt_b},  sat4(e.beat));
            end
        end
    end

    initial begin
        logic [127:0] zero;
        zero     = 128'd0;
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 128'd0;
        gen      = 16'hFFFF;
        d        = 128'd0;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, zero, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, zero, 1'b0, 1'b0, 0, 0);
        // All-zero beats in HUNT: no seeding
        cyc(1'b0, 1'b0, 1'b1, zero, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, zero, 1'b0, 1'b0, 0, 0);
        // Beat 1 seeds, beats 2..5 verify; locked after beat 5
        for (int k = 0; k < 4; k++) begin
            next_beat(d);
            cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 0, 0);
        end
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 0, 0);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 0, 1);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 0, 2);
        // Single bit error in word 3, then clean beat (no reseed)
        next_beat(d); d[48] = ~d[48];
        cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b1, 1, 3);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 1, 4);
        // Valid gaps
        cyc(1'b0, 1'b0, 1'b0, d, 1'b1, 1'b0, 1, 4);
        cyc(1'b0, 1'b0, 1'b0, d, 1'b1, 1'b0, 1, 4);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 1, 5);
        // Three beats with word 0 inverted: unlock after the third
        next_beat(d); d[15:0] = ~d[15:0];
        cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b1, 17, 6);
        next_beat(d); d[15:0] = ~d[15:0];
        cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b1, 33, 7);
        next_beat(d); d[15:0] = ~d[15:0];
        cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b1, 49, 8);
        // Relock: one seed beat plus four verify beats
        for (int k = 0; k < 4; k++) begin
            next_beat(d);
            cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 49, 8);
        end
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 49, 8);
        // Clear, then a fully corrupted beat (4-bit counter saturates at 15)
        cyc(1'b0, 1'b1, 1'b0, d, 1'b1, 1'b0, 0, 0);
        next_beat(d); d = ~d;
        cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b1, 128, 1);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 128, 2);
        // Clear together with an errored beat: counters zero, pulse still fires
        next_beat(d); d[48] = ~d[48];
        cyc(1'b0, 1'b1, 1'b1, d, 1'b1, 1'b1, 0, 0);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 0, 1);
        // Mid-operation reset, then a beat that only seeds
        next_beat(d); cyc(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, 0, 0);
        next_beat(d); cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0, 0, 0);

        // Bounded drain of the scoreboard
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() != 0) begin
                @(posedge clk);
                #3;
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
